// File: rtl/cv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cv_ctrl_pkg
// Brief  : Shared ColecoVision controller constants, scan states and keypad
//          nibble decode.
// Rev    : 1.0
// ============================================================================
package cv_ctrl_pkg;

    // Keypad nibbles as {p1,p2,p3,p4}, read while the keypad strobe is low
    localparam logic [3:0] cv_key_0_c      = 4'b0011;
    localparam logic [3:0] cv_key_1_c      = 4'b1110;
    localparam logic [3:0] cv_key_2_c      = 4'b1101;
    localparam logic [3:0] cv_key_3_c      = 4'b0110;
    localparam logic [3:0] cv_key_4_c      = 4'b0001;
    localparam logic [3:0] cv_key_5_c      = 4'b1001;
    localparam logic [3:0] cv_key_6_c      = 4'b0111;
    localparam logic [3:0] cv_key_7_c      = 4'b1100;
    localparam logic [3:0] cv_key_8_c      = 4'b1000;
    localparam logic [3:0] cv_key_9_c      = 4'b1011;
    localparam logic [3:0] cv_key_star_c   = 4'b1010;
    localparam logic [3:0] cv_key_hash_c   = 4'b0101;
    localparam logic [3:0] cv_key_purple_c = 4'b0100;
    localparam logic [3:0] cv_key_blue_c   = 4'b0010;

    localparam int KP_STAR   = 10;
    localparam int KP_HASH   = 11;
    localparam int KP_PURPLE = 12;
    localparam int KP_BLUE   = 13;
    localparam int KP_UP     = 14;
    localparam int KP_DOWN   = 15;
    localparam int KP_LEFT   = 16;
    localparam int KP_RIGHT  = 17;
    localparam int KP_FIRE   = 18;
    localparam int KP_ARM    = 19;

    typedef enum logic [1:0] {
        ST_KP_SEL = 2'd0,
        ST_GAP    = 2'd1,
        ST_JS_SEL = 2'd2,
        ST_UPDATE = 2'd3
    } cv_scan_state_e;

    // One-hot over bits 0..13 of the bitmap; 1111 and 0000 mean no key
    function automatic logic [13:0] cv_decode_nibble(input logic [3:0] nib);
        logic [13:0] key;
        key = '0;
        case (nib)
            cv_key_0_c:      key[0]         = 1'b1;
            cv_key_1_c:      key[1]         = 1'b1;
            cv_key_2_c:      key[2]         = 1'b1;
            cv_key_3_c:      key[3]         = 1'b1;
            cv_key_4_c:      key[4]         = 1'b1;
            cv_key_5_c:      key[5]         = 1'b1;
            cv_key_6_c:      key[6]         = 1'b1;
            cv_key_7_c:      key[7]         = 1'b1;
            cv_key_8_c:      key[8]         = 1'b1;
            cv_key_9_c:      key[9]         = 1'b1;
            cv_key_star_c:   key[KP_STAR]   = 1'b1;
            cv_key_hash_c:   key[KP_HASH]   = 1'b1;
            cv_key_purple_c: key[KP_PURPLE] = 1'b1;
            cv_key_blue_c:   key[KP_BLUE]   = 1'b1;
            default:         key            = '0;
        endcase
        return key;
    endfunction

endpackage : cv_ctrl_pkg
`default_nettype wire

// File: rtl/cv_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module : cv_ctrl_debounce
// Brief  : Publishes a scanned 20-bit bitmap once DEBOUNCE consecutive scans
//          agree.
// Rev    : 1.0
// ============================================================================
module cv_ctrl_debounce
    import cv_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        update_i,
    input  logic [19:0] raw_i,
    output logic [19:0] keypad_o
);

    localparam logic [3:0] c_debounce = 4'(DEBOUNCE);

    logic [19:0] r_prev;
    logic [3:0]  r_stable_cnt;
    logic [19:0] r_keypad;
    logic [3:0]  w_cnt_next;

    always_comb begin
        w_cnt_next = 4'd1;
        if (raw_i == r_prev) begin
            w_cnt_next = (r_stable_cnt == c_debounce) ? r_stable_cnt
                                                      : r_stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_prev       <= '0;
            r_stable_cnt <= '0;
            r_keypad     <= '0;
        end else if (update_i) begin
            r_stable_cnt <= w_cnt_next;
            if (raw_i != r_prev) begin
                r_prev <= raw_i;
            end
            // Keeps republishing while saturated, which is harmless
            if (w_cnt_next == c_debounce) begin
                r_keypad <= raw_i;
            end
        end
    end

    assign keypad_o = r_keypad;

endmodule : cv_ctrl_debounce
`default_nettype wire

// File: rtl/cv_ctrl_scanner.sv
`default_nettype none
// ============================================================================
// Module : cv_ctrl_scanner
// Brief  : Strobes and samples two ColecoVision controller ports, producing
//          debounced 20-bit key bitmaps.
// Rev    : 1.0
// ============================================================================
module cv_ctrl_scanner
    import cv_ctrl_pkg::*;
#(
    parameter int SETTLE   = 64,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clk_en_i,
    output logic [1:0]  ctrl_p5_o,
    output logic [1:0]  ctrl_p8_o,
    input  logic [1:0]  ctrl_p1_i,
    input  logic [1:0]  ctrl_p2_i,
    input  logic [1:0]  ctrl_p3_i,
    input  logic [1:0]  ctrl_p4_i,
    input  logic [1:0]  ctrl_p6_i,
    output logic [19:0] keypad0_o,
    output logic [19:0] keypad1_o,
    output logic        valid_o
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE - 1);

    logic [9:0]     r_meta;
    logic [9:0]     r_sync;
    cv_scan_state_e r_state;
    logic [7:0]     r_settle_cnt;
    logic [19:0]    r_raw [2];
    logic [1:0]     r_p5;
    logic [1:0]     r_p8;
    logic           r_valid;
    logic           r_update;
    logic [19:0]    w_keypad [2];

    logic [1:0] w_p1;
    logic [1:0] w_p2;
    logic [1:0] w_p3;
    logic [1:0] w_p4;
    logic [1:0] w_p6;

    // Pins are idle-high, so the synchronizer resets to released lines
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= {ctrl_p6_i, ctrl_p4_i, ctrl_p3_i, ctrl_p2_i, ctrl_p1_i};
            r_sync <= r_meta;
        end
    end

    assign w_p1 = r_sync[1:0];
    assign w_p2 = r_sync[3:2];
    assign w_p3 = r_sync[5:4];
    assign w_p4 = r_sync[7:6];
    assign w_p6 = r_sync[9:8];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_KP_SEL;
            r_settle_cnt <= '0;
            r_raw[0]     <= '0;
            r_raw[1]     <= '0;
            r_p5         <= 2'b11;
            r_p8         <= 2'b11;
            r_valid      <= 1'b0;
            r_update     <= 1'b0;
        end else begin
            // Strobes follow the state one clock later, every clock
            r_p5     <= (r_state == ST_KP_SEL) ? 2'b00 : 2'b11;
            r_p8     <= (r_state == ST_JS_SEL) ? 2'b00 : 2'b11;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
            if (clk_en_i) begin
                case (r_state)
                    ST_KP_SEL: begin
                        if (r_settle_cnt == c_settle_last) begin
                            r_settle_cnt <= '0;
                            r_state      <= ST_GAP;
                            for (int p = 0; p < 2; p++) begin
                                r_raw[p][13:0]   <= cv_decode_nibble(
                                    {w_p1[p], w_p2[p], w_p3[p], w_p4[p]});
                                r_raw[p][KP_ARM] <= ~w_p6[p];
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end
                    end
                    ST_GAP: begin
                        r_state <= ST_JS_SEL;
                    end
                    ST_JS_SEL: begin
                        if (r_settle_cnt == c_settle_last) begin
                            r_settle_cnt <= '0;
                            r_state      <= ST_UPDATE;
                            for (int p = 0; p < 2; p++) begin
                                r_raw[p][KP_UP]    <= ~w_p1[p];
                                r_raw[p][KP_DOWN]  <= ~w_p2[p];
                                r_raw[p][KP_LEFT]  <= ~w_p3[p];
                                r_raw[p][KP_RIGHT] <= ~w_p4[p];
                                r_raw[p][KP_FIRE]  <= ~w_p6[p];
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end
                    end
                    ST_UPDATE: begin
                        r_state  <= ST_KP_SEL;
                        r_valid  <= 1'b1;
                        r_update <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_KP_SEL;
                    end
                endcase
            end
        end
    end

    // The debouncers commit on the same edge that raises valid_o
    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            cv_ctrl_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_debounce (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .update_i  (clk_en_i && (r_state == ST_UPDATE)),
                .raw_i     (r_raw[p]),
                .keypad_o  (w_keypad[p])
            );
        end
    endgenerate

    assign ctrl_p5_o = r_p5;
    assign ctrl_p8_o = r_p8;
    assign keypad0_o = w_keypad[0];
    assign keypad1_o = w_keypad[1];
    assign valid_o   = r_valid;

endmodule : cv_ctrl_scanner
`default_nettype wire

// File: tb/tb_cv_ctrl_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_cv_ctrl_scanner
// Brief  : Randomized bench with a controller model and a scan-level reference.
// Rev    : 1.0
// ============================================================================
module tb_cv_ctrl_scanner;

    localparam int SETTLE_P = 4;
    localparam int DB_P     = 2;
    localparam int SCAN_CLK = (2 * SETTLE_P + 2) * 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en;
    logic [1:0]  p5, p8, p1, p2, p3, p4, p6;
    logic [19:0] kp0, kp1;
    logic        valid;

    logic [1:0] ce_div = 2'd0;
    int         cyc = 0;

    // Controller state as a human would hold it
    logic [3:0] nib  [2];
    logic       arm  [2];
    logic       fire [2];
    logic [3:0] joy  [2];   // {right,left,down,up}

    int          key_of [16];
    logic [19:0] hist   [2][DB_P];
    int          nvalid [2];
    logic [19:0] exp_kp [2];
    int          last_valid = -1;
    int          n_checks = 0;
    int          n_pass = 0;

    cv_ctrl_scanner #(
        .SETTLE   (SETTLE_P),
        .DEBOUNCE (DB_P)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .clk_en_i  (clk_en),
        .ctrl_p5_o (p5),
        .ctrl_p8_o (p8),
        .ctrl_p1_i (p1),
        .ctrl_p2_i (p2),
        .ctrl_p3_i (p3),
        .ctrl_p4_i (p4),
        .ctrl_p6_i (p6),
        .keypad0_o (kp0),
        .keypad1_o (kp1),
        .valid_o   (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_div <= ce_div + 2'd1;
        cyc    <= cyc + 1;
    end
    assign clk_en = (ce_div == 2'd3);

    // A real controller answers whichever strobe is pulled low
    always_comb begin
        p1 = 2'b11; p2 = 2'b11; p3 = 2'b11; p4 = 2'b11; p6 = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (!p5[i]) begin
                p1[i] = nib[i][3]; p2[i] = nib[i][2];
                p3[i] = nib[i][1]; p4[i] = nib[i][0];
                p6[i] = ~arm[i];
            end else if (!p8[i]) begin
                p1[i] = ~joy[i][0]; p2[i] = ~joy[i][1];
                p3[i] = ~joy[i][2]; p4[i] = ~joy[i][3];
                p6[i] = ~fire[i];
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [19:0] expected_raw(input int p);
        logic [19:0] r;
        r = '0;
        if (key_of[nib[p]] >= 0) r[key_of[nib[p]]] = 1'b1;
        r[17:14] = joy[p];
        r[18]    = fire[p];
        r[19]    = arm[p];
        return r;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            nvalid[p] = 0;
            exp_kp[p] = '0;
            for (int k = 0; k < DB_P; k++) hist[p][k] = '0;
        end
    endfunction

    // Output follows the raw bitmap once the last DB_P scans all agree
    function automatic void model_scan();
        for (int p = 0; p < 2; p++) begin
            logic [19:0] r;
            bit          agree;
            r = expected_raw(p);
            for (int k = DB_P - 1; k > 0; k--) hist[p][k] = hist[p][k-1];
            hist[p][0] = r;
            if (nvalid[p] < DB_P) nvalid[p]++;
            agree = (nvalid[p] == DB_P);
            for (int k = 0; k < DB_P; k++) if (hist[p][k] != r) agree = 0;
            if (agree) exp_kp[p] = r;
        end
    endfunction

    task automatic set_idle(input int p);
        nib[p] = 4'b1111; arm[p] = 1'b0; fire[p] = 1'b0; joy[p] = 4'b0000;
    endtask

    task automatic do_scan();
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 * SCAN_CLK && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        check_value("valid_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (last_valid >= 0) check_value("valid_period", cyc - last_valid, SCAN_CLK);
        last_valid = cyc;
        model_scan();
        check_value("keypad0", 32'(kp0), 32'(exp_kp[0]));
        check_value("keypad1", 32'(kp1), 32'(exp_kp[1]));
        @(negedge clk);
        check_value("valid_width", 32'(valid), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        bit pulsed;
        pulsed = 0;
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid) pulsed = 1;
        end
        check_value("rst_p5", 32'(p5), 32'h3);
        check_value("rst_p8", 32'(p8), 32'h3);
        check_value("rst_kp0", 32'(kp0), 32'h0);
        check_value("rst_kp1", 32'(kp1), 32'h0);
        check_value("rst_no_valid", 32'(pulsed), 32'd0);
        model_reset();
        last_valid = -1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("release_p5", 32'(p5), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        for (int n = 0; n < 16; n++) key_of[n] = -1;
        key_of[4'b0011] = 0;  key_of[4'b1110] = 1;  key_of[4'b1101] = 2;
        key_of[4'b0110] = 3;  key_of[4'b0001] = 4;  key_of[4'b1001] = 5;
        key_of[4'b0111] = 6;  key_of[4'b1100] = 7;  key_of[4'b1000] = 8;
        key_of[4'b1011] = 9;  key_of[4'b1010] = 10; key_of[4'b0101] = 11;
        key_of[4'b0100] = 12; key_of[4'b0010] = 13;
        set_idle(0);
        set_idle(1);
        model_reset();

        apply_reset(10);

        // Idle baseline, then key 5 on port 0
        do_scan();
        nib[0] = 4'b1001;
        do_scan();
        do_scan();
        check_value("key5_kp0", 32'(kp0), 32'h00020);
        check_value("key5_kp1", 32'(kp1), 32'h0);

        // Port 1 up + fire with button 2 released
        set_idle(0);
        joy[1] = 4'b0001; fire[1] = 1'b1;
        do_scan();
        do_scan();
        check_value("upfire_kp1", 32'(kp1), 32'h44000);

        // Invalid nibble with arm pressed
        set_idle(1);
        nib[0] = 4'b0000; arm[0] = 1'b1;
        do_scan();
        do_scan();
        check_value("invalid_kp0", 32'(kp0), 32'h80000);

        // One-scan glitch of key 1 must never reach the output
        set_idle(0);
        do_scan();
        do_scan();
        nib[0] = 4'b1110;
        do_scan();
        check_value("glitch_kp0_a", 32'(kp0), 32'h0);
        set_idle(0);
        do_scan();
        check_value("glitch_kp0_b", 32'(kp0), 32'h0);
        do_scan();

        // Random controller activity, often held so debounce can settle
        for (int s = 0; s < 30; s++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 0) begin
                    nib[p]  = 4'($urandom_range(0, 15));
                    arm[p]  = 1'($urandom_range(0, 1));
                    fire[p] = 1'($urandom_range(0, 1));
                    joy[p]  = 4'($urandom_range(0, 15));
                end
            end
            do_scan();
        end

        // Reset while the joystick strobe is active
        nib[0] = 4'b0011; joy[1] = 4'b1000;
        do_scan();
        do_scan();
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 2 * SCAN_CLK && !found; i++) begin
                @(negedge clk);
                if (p8 == 2'b00) found = 1;
            end
            check_value("js_sel_reached", 32'(found), 32'd1);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_value("midrst_p8", 32'(p8), 32'h3);
        check_value("midrst_kp0", 32'(kp0), 32'h0);
        check_value("midrst_valid", 32'(valid), 32'd0);
        apply_reset(4);
        for (int s = 0; s < 3; s++) do_scan();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cv_ctrl_scanner
`default_nettype wire
